call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter PC_WIDTH, default 11, width of a stored return address (the instruction immediate field in_ir[10:0]).
REQ-002 Parameter FLAG_WIDTH, default 4, width of the stored ALU flags (matches in_alu_flags).
REQ-003 Parameter DEPTH, default 5, number of stack entries; legal range 2..7.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_push  input  1  push {in_pc, in_flags} this cycle (call).
REQ-007 in_pop  input  1  pop top entry this cycle (ret).
REQ-008 in_pc  input  PC_WIDTH  return address to save.
REQ-009 in_flags  input  FLAG_WIDTH  flags to save.
REQ-010 in_clear_err  input  1  clears sticky error flags (present only with CALL_STACK_ERR_EN).
REQ-011 out_pc  output  PC_WIDTH  top-of-stack return address.
REQ-012 out_flags  output  FLAG_WIDTH  top-of-stack flags.
REQ-013 out_sp  output  3  current entry count, 0..DEPTH.
REQ-014 out_empty  output  1  high when out_sp == 0.
REQ-015 out_full  output  1  high when out_sp == DEPTH.
REQ-016 out_overflow  output  1  sticky: push attempted while full.
REQ-017 out_underflow  output  1  sticky: pop attempted while empty.

Function
REQ-018 Storage SHALL be DEPTH registers of PC_WIDTH+FLAG_WIDTH bits plus a 3-bit stack pointer sp; no RAM inference required.
REQ-019 out_pc/out_flags SHALL be combinational from entry[sp-1] (zero-latency peek), and SHALL be all-zero when sp == 0.
REQ-020 Push only, not full: entry[sp] <= {in_pc,in_flags}, sp <= sp+1; new top visible the cycle after the edge.
REQ-021 Pop only, not empty: sp <= sp-1; popped entry contents need not be cleared.
REQ-022 Push and pop same cycle, not empty: entry[sp-1] <= {in_pc,in_flags}, sp unchanged (replace top).
REQ-023 Push and pop same cycle, empty: behave as push only; no underflow flagged.
REQ-024 Push while full (without pop): stack, sp unchanged; overflow event raised.
REQ-025 Pop while empty (without push): sp stays 0; underflow event raised.
REQ-026 sp SHALL never exceed DEPTH nor wrap below 0 under any input sequence.
REQ-027 out_empty/out_full SHALL be combinational from sp, mutually exclusive.
REQ-028 Consumer usage: control unit samples out_pc/out_flags, then asserts in_pop in the same cycle it loads PC and flags.

Reset
REQ-029 rst high at a rising edge SHALL set sp to 0 and clear out_overflow/out_underflow; entry contents are don't-care.
REQ-030 After reset: out_pc=0, out_flags=0, out_sp=0, out_empty=1, out_full=0.
REQ-031 rst SHALL take priority over in_push, in_pop and in_clear_err in the same cycle.

Configuration
REQ-032 Macro CALL_STACK_ERR_EN: when defined, out_overflow/out_underflow are sticky registers set by REQ-024/REQ-025 events and cleared by rst or in_clear_err (set wins over clear in the same cycle); in_clear_err is a port.
REQ-033 Without CALL_STACK_ERR_EN: in_clear_err port is absent, out_overflow and out_underflow are tied to 0, and push-while-full/pop-while-empty are silently ignored per REQ-024/REQ-025.

Verification
REQ-034 Reset, then idle 3 cycles -> out_sp=0, out_empty=1, out_pc=0, out_flags=0.
REQ-035 Push (pc=0x123,f=0xA) then (0x045,0x3) -> out_sp=2, out_pc=0x045, out_flags=0x3; pop -> out_pc=0x123, out_flags=0xA, out_sp=1.
REQ-036 Push 5 distinct entries then a 6th (0x7FF) -> out_full=1, out_sp=5, top still 5th entry, out_overflow=1 (macro on) / 0 (macro off).
REQ-037 From empty pop once -> out_sp=0, out_underflow=1 (macro on); assert in_clear_err -> out_underflow=0 next cycle.
REQ-038 With sp=2, push+pop together (0x1AA,0xF) -> out_sp=2, out_pc=0x1AA, out_flags=0xF; with sp=0 push+pop -> out_sp=1, no underflow.
REQ-039 With sp=3, assert rst together with in_push -> out_sp=0, out_empty=1, error flags cleared.

Source files
------------

// File: rtl/call_stack.sv
// Return-address/flags stack for call and ret instructions with a zero-latency top peek.
// Defining CALL_STACK_ERR_EN adds sticky overflow/underflow flags and the in_clear_err port.
module call_stack #(
    parameter int PC_WIDTH   = 11,
    parameter int FLAG_WIDTH = 4,
    parameter int DEPTH      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_push,
    input  logic                  in_pop,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [FLAG_WIDTH-1:0] in_flags,
`ifdef CALL_STACK_ERR_EN
    input  logic                  in_clear_err,
`endif
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [FLAG_WIDTH-1:0] out_flags,
    output logic [2:0]            out_sp,
    output logic                  out_empty,
    output logic                  out_full,
    output logic                  out_overflow,
    output logic                  out_underflow
);

    localparam int W = PC_WIDTH + FLAG_WIDTH;
    localparam logic [2:0] DEPTH3 = 3'(DEPTH);

    logic [W-1:0] entry [DEPTH];
    logic [2:0]   sp;
    logic [2:0]   wr_idx;
    logic [W-1:0] top;
    logic         empty;
    logic         full;
    logic         repl;
    logic         psh;
    logic         pop;

    assign empty = (sp == 3'd0);
    assign full  = (sp == DEPTH3);

    // A push that meets a pop on a non-empty stack overwrites the top in place.
    assign repl   = in_push && in_pop && !empty;
    assign psh    = in_push && !repl && !full;
    assign pop    = in_pop && !in_push && !empty;
    assign wr_idx = repl ? sp - 3'd1 : sp;

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == 3'(i + 1)) top = entry[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= 3'd0;
        end else if (psh) begin
            sp <= sp + 3'd1;
        end else if (pop) begin
            sp <= sp - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((repl || psh) && wr_idx == 3'(i)) entry[i] <= {in_pc, in_flags};
        end
    end

`ifdef CALL_STACK_ERR_EN
    logic ovf;
    logic unf;
    logic ovf_ev;
    logic unf_ev;

    assign ovf_ev = in_push && !in_pop && full;
    assign unf_ev = in_pop && !in_push && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_ev) ovf <= 1'b1;
            else if (in_clear_err) ovf <= 1'b0;
            if (unf_ev) unf <= 1'b1;
            else if (in_clear_err) unf <= 1'b0;
        end
    end

    assign out_overflow  = ovf;
    assign out_underflow = unf;
`else
    assign out_overflow  = 1'b0;
    assign out_underflow = 1'b0;
`endif

    assign out_pc    = top[W-1:FLAG_WIDTH];
    assign out_flags = top[FLAG_WIDTH-1:0];
    assign out_sp    = sp;
    assign out_empty = empty;
    assign out_full  = full;

endmodule

// File: tb/tb_call_stack.sv
// Directed-vector bench for call_stack; expectations follow CALL_STACK_ERR_EN.
`timescale 1ns/1ps
module tb_call_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_push;
    logic        in_pop;
    logic [10:0] in_pc;
    logic [3:0]  in_flags;
`ifdef CALL_STACK_ERR_EN
    logic        in_clear_err;
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif
    logic [10:0] out_pc;
    logic [3:0]  out_flags;
    logic [2:0]  out_sp;
    logic        out_empty;
    logic        out_full;
    logic        out_overflow;
    logic        out_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    call_stack dut (
        .clk(clk),
        .rst(rst),
        .in_push(in_push),
        .in_pop(in_pop),
        .in_pc(in_pc),
        .in_flags(in_flags),
`ifdef CALL_STACK_ERR_EN
        .in_clear_err(in_clear_err),
`endif
        .out_pc(out_pc),
        .out_flags(out_flags),
        .out_sp(out_sp),
        .out_empty(out_empty),
        .out_full(out_full),
        .out_overflow(out_overflow),
        .out_underflow(out_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given controls; returns 1ns after the edge.
    task automatic cyc(input logic r, input logic p, input logic q,
                       input logic [10:0] pc, input logic [3:0] f);
        rst = r;
        in_push = p;
        in_pop = q;
        in_pc = pc;
        in_flags = f;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_push = 1'b0;
        in_pop = 1'b0;
    endtask

    task automatic top_is(input string tag, input logic [2:0] sp,
                          input logic [10:0] pc, input logic [3:0] f);
        check({tag, "_sp"}, 32'(out_sp), 32'(sp));
        check({tag, "_pc"}, 32'(out_pc), 32'(pc));
        check({tag, "_flags"}, 32'(out_flags), 32'(f));
    endtask

    initial begin
        rst = 1'b1;
        in_push = 1'b0;
        in_pop = 1'b0;
        in_pc = '0;
        in_flags = '0;
`ifdef CALL_STACK_ERR_EN
        in_clear_err = 1'b0;
`endif
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        top_is("reset", 0, 11'h000, 4'h0);
        check("reset_empty", 32'(out_empty), 1);
        check("reset_full", 32'(out_full), 0);
        check("reset_ovf", 32'(out_overflow), 0);
        check("reset_unf", 32'(out_underflow), 0);

        cyc(0, 1, 0, 11'h123, 4'hA);
        top_is("push1", 1, 11'h123, 4'hA);
        cyc(0, 1, 0, 11'h045, 4'h3);
        top_is("push2", 2, 11'h045, 4'h3);
        check("push2_empty", 32'(out_empty), 0);
        cyc(0, 0, 1, 0, 0);
        top_is("pop1", 1, 11'h123, 4'hA);
        cyc(0, 0, 1, 0, 0);
        top_is("pop2", 0, 11'h000, 4'h0);
        check("pop2_empty", 32'(out_empty), 1);

        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 11'h101 + 11'(i), 4'(i + 1));
        top_is("fill5", 5, 11'h105, 4'h5);
        check("fill5_full", 32'(out_full), 1);
        check("fill5_empty", 32'(out_empty), 0);
        check("fill5_ovf", 32'(out_overflow), 0);
        cyc(0, 1, 0, 11'h7FF, 4'hF);
        top_is("push6", 5, 11'h105, 4'h5);
        check("push6_full", 32'(out_full), 1);
        check("push6_ovf", 32'(out_overflow), 32'(ERR));
        cyc(0, 1, 1, 11'h333, 4'h6);
        top_is("full_repl", 5, 11'h333, 4'h6);
        top_is("full_repl_pop", 5, 11'h333, 4'h6);
        cyc(0, 0, 1, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            top_is("drain", 3'(i + 1), 11'h101 + 11'(i), 4'(i + 1));
            cyc(0, 0, 1, 0, 0);
        end
        top_is("drained", 0, 11'h000, 4'h0);
        check("drained_unf", 32'(out_underflow), 0);

        cyc(0, 0, 1, 0, 0);
        check("under_sp", 32'(out_sp), 0);
        check("under_empty", 32'(out_empty), 1);
        check("under_unf", 32'(out_underflow), 32'(ERR));
        check("under_ovf_kept", 32'(out_overflow), 32'(ERR));
`ifdef CALL_STACK_ERR_EN
        in_clear_err = 1'b1;
        cyc(0, 0, 1, 0, 0);
        check("set_wins_unf", 32'(out_underflow), 1);
        check("set_wins_ovf", 32'(out_overflow), 0);
        cyc(0, 0, 0, 0, 0);
        in_clear_err = 1'b0;
        check("clear_unf", 32'(out_underflow), 0);
        check("clear_ovf", 32'(out_overflow), 0);
`endif

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 11'h010, 4'h1);
        cyc(0, 1, 0, 11'h020, 4'h2);
        cyc(0, 1, 1, 11'h1AA, 4'hF);
        top_is("repl", 2, 11'h1AA, 4'hF);
        cyc(0, 0, 1, 0, 0);
        top_is("repl_pop", 1, 11'h010, 4'h1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 11'h055, 4'h5);
        top_is("pp_empty", 1, 11'h055, 4'h5);
        check("pp_empty_unf", 32'(out_underflow), 0);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("pre_rst_unf", 32'(out_underflow), 32'(ERR));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 11'h200 + 11'(i), 4'h9);
        check("pre_rst_sp", 32'(out_sp), 3);
`ifdef CALL_STACK_ERR_EN
        in_clear_err = 1'b1;
`endif
        cyc(1, 1, 0, 11'h3FF, 4'hC);
`ifdef CALL_STACK_ERR_EN
        in_clear_err = 1'b0;
`endif
        top_is("rst_push", 0, 11'h000, 4'h0);
        check("rst_push_empty", 32'(out_empty), 1);
        check("rst_push_unf", 32'(out_underflow), 0);
        check("rst_push_ovf", 32'(out_overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
